// File: rtl/fifo_s8_s1_rd.sv
// Byte-in, bit-out FIFO: 512 x 8 write port, 4096 x 1 read port, registered read bit.
// MSB_FIRST selects whether each byte is read out bit 0..7 or bit 7..0.
module fifo_s8_s1_rd #(
  parameter int MSB_FIRST = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  DI,
  input  logic        WE,
  output logic        FULL,
  input  logic        RE,
  output logic        DO,
  output logic        DO_VALID,
  output logic        EMPTY,
  output logic [12:0] BIT_COUNT,
  output logic        OVF,
  output logic        UDF
);

  logic [7:0]  mem [0:511];
  logic [8:0]  wr_ptr;
  logic [11:0] rd_ptr;
  logic        wr_ok;
  logic        rd_ok;
  logic [2:0]  bit_sel;
  logic [7:0]  rd_byte;
  logic [12:0] count_nxt;

  // Acceptance uses the registered flags, so a simultaneous write and read see pre-edge state.
  assign wr_ok   = WE & ~FULL;
  assign rd_ok   = RE & ~EMPTY;
  assign bit_sel = (MSB_FIRST != 0) ? ~rd_ptr[2:0] : rd_ptr[2:0];
  assign rd_byte = mem[rd_ptr[11:3]];

  // NOTE: assign a default before the case so every path drives count_nxt and no latch is inferred.
  always_comb begin
    count_nxt = BIT_COUNT;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = BIT_COUNT + 13'd8;
      2'b01:   count_nxt = BIT_COUNT - 13'd1;
      2'b11:   count_nxt = BIT_COUNT + 13'd7;
      default: count_nxt = BIT_COUNT;
    endcase
  end

  // NOTE: storage is deliberately not reset; after reset the count is zero, so stale bytes can never be read.
  always_ff @(posedge CLK) begin
    if (wr_ok && !RST) begin
      mem[wr_ptr] <= DI;
    end
  end

  // NOTE: all state updates use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      BIT_COUNT <= '0;
      FULL      <= 1'b0;
      EMPTY     <= 1'b1;
      DO        <= 1'b0;
      DO_VALID  <= 1'b0;
      OVF       <= 1'b0;
      UDF       <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 9'd1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 12'd1;
        DO     <= rd_byte[bit_sel];
      end
      DO_VALID  <= rd_ok;
      OVF       <= WE & FULL;
      UDF       <= RE & EMPTY;
      BIT_COUNT <= count_nxt;
      // A margin of 8 free bits keeps the byte under partial read from being overwritten.
      FULL      <= (count_nxt > 13'd4088);
      EMPTY     <= (count_nxt == 13'd0);
    end
  end

endmodule

// File: tb/tb_fifo_s8_s1_rd.sv
// Bench for fifo_s8_s1_rd: LSB-first and MSB-first instances share stimulus and are
// compared every cycle against a bit-queue model, plus hand-computed directed checks.
module tb_fifo_s8_s1_rd;

  logic        clk = 1'b0;
  logic        rst, we, re;
  logic [7:0]  di;
  logic        full0, do0, dv0, empty0, ovf0, udf0;
  logic        full1, do1, dv1, empty1, ovf1, udf1;
  logic [12:0] cnt0, cnt1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain FIFOs of bits in read order for each bit ordering.
  bit   q0[$];
  bit   q1[$];
  logic e_do0, e_do1, e_dv, e_ovf, e_udf;
  bit   model_ok = 1'b0;

  fifo_s8_s1_rd #(.MSB_FIRST(0)) dut0 (
    .CLK(clk), .RST(rst), .DI(di), .WE(we), .FULL(full0), .RE(re), .DO(do0),
    .DO_VALID(dv0), .EMPTY(empty0), .BIT_COUNT(cnt0), .OVF(ovf0), .UDF(udf0)
  );

  fifo_s8_s1_rd #(.MSB_FIRST(1)) dut1 (
    .CLK(clk), .RST(rst), .DI(di), .WE(we), .FULL(full1), .RE(re), .DO(do1),
    .DO_VALID(dv1), .EMPTY(empty1), .BIT_COUNT(cnt1), .OVF(ovf1), .UDF(udf1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic w, input logic [7:0] d, input logic rd);
    int sz = q0.size();
    bit full_pre = (sz > 4088);
    bit empty_pre = (sz == 0);
    if (r) begin
      q0.delete();
      q1.delete();
      e_do0 = 1'b0; e_do1 = 1'b0;
      e_dv = 1'b0; e_ovf = 1'b0; e_udf = 1'b0;
      model_ok = 1'b1;
    end else begin
      e_dv  = rd && !empty_pre;
      e_ovf = w && full_pre;
      e_udf = rd && empty_pre;
      if (e_dv) begin
        e_do0 = q0.pop_front();
        e_do1 = q1.pop_front();
      end
      if (w && !full_pre) begin
        for (int i = 0; i < 8; i++) begin
          q0.push_back(d[i]);
          q1.push_back(d[7-i]);
        end
      end
    end
  endtask

  // Drive inputs while the clock is low, update the model at the edge, return on the falling edge.
  task automatic cycle(input logic r, input logic w, input logic [7:0] d, input logic rd);
    rst = r; we = w; di = d; re = rd;
    @(posedge clk);
    model_step(r, w, d, rd);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      check("do_lsb",    {31'd0, do0},    {31'd0, e_do0});
      check("do_msb",    {31'd0, do1},    {31'd0, e_do1});
      check("valid_lsb", {31'd0, dv0},    {31'd0, e_dv});
      check("valid_msb", {31'd0, dv1},    {31'd0, e_dv});
      check("count_lsb", {19'd0, cnt0},   q0.size());
      check("count_msb", {19'd0, cnt1},   q1.size());
      check("full",      {31'd0, full0},  {31'd0, (q0.size() > 4088)});
      check("empty",     {31'd0, empty0}, {31'd0, (q0.size() == 0)});
      check("full_msb",  {31'd0, full1},  {31'd0, (q1.size() > 4088)});
      check("empty_msb", {31'd0, empty1}, {31'd0, (q1.size() == 0)});
      check("ovf",       {30'd0, ovf0, ovf1}, {30'd0, e_ovf, e_ovf});
      check("udf",       {30'd0, udf0, udf1}, {30'd0, e_udf, e_udf});
    end
  end

  initial begin
    logic [7:0] s0, s1;
    rst = 1'b1; we = 1'b0; re = 1'b0; di = 8'h00;

    cycle(1, 0, 8'h00, 0);
    cycle(1, 1, 8'hFF, 1);
    check("rst_count", {19'd0, cnt0}, 32'd0);
    check("rst_flags", {26'd0, empty0, full0, do0, dv0, ovf0, udf0}, 32'b100000);

    // 8'hA5 is bit-reversal symmetric, so both orders yield the same sequence.
    cycle(0, 1, 8'hA5, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 8'h00, 1);
      check("a5_valid", {31'd0, dv0}, 32'd1);
      s0[i] = do0; s1[i] = do1;
    end
    check("a5_seq_lsb", {24'd0, s0}, 32'hA5);
    check("a5_seq_msb", {24'd0, s1}, 32'hA5);
    check("a5_drained", {18'd0, empty0, cnt0}, {18'd0, 1'b1, 13'd0});

    cycle(0, 1, 8'h01, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 8'h00, 1);
      s0[i] = do0; s1[i] = do1;
    end
    check("01_seq_lsb", {24'd0, s0}, 32'h01);
    check("01_seq_msb", {24'd0, s1}, 32'h80);

    cycle(0, 0, 8'h00, 1);
    check("udf_pulse", {29'd0, udf0, dv0, empty0}, 32'b101);
    check("udf_do_hold", {30'd0, do0, do1}, 32'b01);
    cycle(0, 0, 8'h00, 0);
    check("udf_clear", {31'd0, udf0}, 32'd0);

    cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < 511; i++) cycle(0, 1, 8'($urandom), 0);
    check("fill_511", {18'd0, full0, cnt0}, {18'd0, 1'b0, 13'd4088});
    cycle(0, 1, 8'($urandom), 0);
    check("fill_512", {18'd0, full0, cnt0}, {18'd0, 1'b1, 13'd4096});
    cycle(0, 1, 8'h3C, 0);
    check("fill_ovf", {18'd0, ovf0, cnt0}, {18'd0, 1'b1, 13'd4096});
    for (int i = 0; i < 8; i++) cycle(0, 0, 8'h00, 1);
    check("fill_drain8", {18'd0, full0, cnt0}, {18'd0, 1'b0, 13'd4088});

    cycle(1, 0, 8'h00, 0);
    cycle(0, 1, 8'h6D, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 1);
    check("count5", {19'd0, cnt0}, 32'd5);
    cycle(0, 1, 8'h92, 1);
    check("both_count", {18'd0, dv0, cnt0}, {18'd0, 1'b1, 13'd12});

    cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'($urandom), 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 8'h00, 1);
    cycle(1, 1, 8'hFF, 1);
    check("mid_rst", {17'd0, empty0, do0, cnt0}, {17'd0, 1'b1, 1'b0, 13'd0});
    cycle(0, 1, 8'hFF, 0);
    cycle(0, 0, 8'h00, 1);
    check("after_rst_ff", {29'd0, dv0, do0, do1}, 32'b111);

    // Alternating fill-heavy and drain-heavy phases push far more than 4096 bits through.
    for (int c = 0; c < 12000; c++) begin
      bit fill = ((c / 1500) % 2) == 0;
      logic w = fill ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 1);
      logic r = fill ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 9);
      logic x = ($urandom_range(0, 3999) == 0);
      cycle(x, w, 8'($urandom), r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
